arbitro_mux4: RTL and testbench

- Round-robin arbiter that shares one 4-input, LARGURA-bit selection path between four requesters.
- Each requester presents a word and a request. The block picks a winner, drives the mux select, and captures the selected word into an output register.
- It presents the captured word downstream with a valid/ready handshake.
- Sits between the register-file/ALU-side producers and the shared write-back bus of the multicycle MIPS datapath.

---
 rtl/arbitro_mux4.sv | 144 ++++++++++++++
 tb/tb_arbitro_mux4.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/arbitro_mux4.sv
// Round-robin arbiter feeding a shared 4:1 mux and an output register with valid/ready handshake.
// Optional ARB_TRAVA_EN macro adds the trava lock input that lets the last winner keep the grant.
module arbitro_mux4 #(
    parameter int LARGURA = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [3:0]         req,
    input  logic [LARGURA-1:0] entrada0,
    input  logic [LARGURA-1:0] entrada1,
    input  logic [LARGURA-1:0] entrada2,
    input  logic [LARGURA-1:0] entrada3,
`ifdef ARB_TRAVA_EN
    input  logic [3:0]         trava,
`endif
    input  logic               pronto,
    output logic [3:0]         ack,
    output logic [1:0]         controlador,
    output logic               saida_valida,
    output logic [LARGURA-1:0] saida_dado
);

    typedef enum logic {
        OCIOSO,
        ENVIANDO
    } estado_t;

    estado_t            estado_q, estado_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [LARGURA-1:0] dado_q, dado_d;
    logic [1:0]         rr;
    logic [1:0]         vencedor;
    logic               retem;
    logic               livre;
    logic               captura;
    logic [LARGURA-1:0] selecionado;

`ifdef ARB_TRAVA_EN
    logic [1:0]         ultimo_q, ultimo_d;
    logic               ultimo_ok_q, ultimo_ok_d;
`endif

    // First set request at or after p, ascending modulo 4; p when none.
    function automatic logic [1:0] busca(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] res;
        logic       achou;
        res   = p;
        achou = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = p + 2'(i);
            if (!achou && r[idx]) begin
                res   = idx;
                achou = 1'b1;
            end
        end
        return res;
    endfunction

    // Winner selection: round-robin, optionally overridden by the lock.
    always_comb begin
        rr    = busca(req, ptr_q);
        retem = 1'b0;
`ifdef ARB_TRAVA_EN
        retem = ultimo_ok_q && trava[ultimo_q] && req[ultimo_q];
`endif
        vencedor = retem ? ultimo_q_sel() : rr;
    end

`ifdef ARB_TRAVA_EN
    function automatic logic [1:0] ultimo_q_sel();
        return ultimo_q;
    endfunction
`else
    function automatic logic [1:0] ultimo_q_sel();
        return 2'd0;
    endfunction
`endif

    // Data path mux driven by the current winner.
    always_comb begin
        selecionado = entrada0;
        case (vencedor)
            2'd0:    selecionado = entrada0;
            2'd1:    selecionado = entrada1;
            2'd2:    selecionado = entrada2;
            default: selecionado = entrada3;
        endcase
    end

    // Next-state, capture and ack generation.
    always_comb begin
        estado_d = estado_q;
        ptr_d    = ptr_q;
        dado_d   = dado_q;
        ack      = 4'b0000;
`ifdef ARB_TRAVA_EN
        ultimo_d    = ultimo_q;
        ultimo_ok_d = ultimo_ok_q;
`endif
        livre   = (estado_q == OCIOSO) || pronto;
        captura = reset_n && livre && (req != 4'b0000);
        if (captura) begin
            ack      = 4'b0001 << vencedor;
            dado_d   = selecionado;
            estado_d = ENVIANDO;
            if (!retem) begin
                ptr_d = vencedor + 2'd1;
            end
`ifdef ARB_TRAVA_EN
            ultimo_d    = vencedor;
            ultimo_ok_d = 1'b1;
`endif
        end else if (livre && estado_q == ENVIANDO) begin
            estado_d = OCIOSO;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            estado_q <= OCIOSO;
            ptr_q    <= 2'd0;
            dado_q   <= '0;
`ifdef ARB_TRAVA_EN
            ultimo_q    <= 2'd0;
            ultimo_ok_q <= 1'b0;
`endif
        end else begin
            estado_q <= estado_d;
            ptr_q    <= ptr_d;
            dado_q   <= dado_d;
`ifdef ARB_TRAVA_EN
            ultimo_q    <= ultimo_d;
            ultimo_ok_q <= ultimo_ok_d;
`endif
        end
    end

    assign controlador  = reset_n ? vencedor : 2'd0;
    assign saida_valida = (estado_q == ENVIANDO);
    assign saida_dado   = dado_q;

endmodule

// File: tb/tb_arbitro_mux4.sv
// Testbench for arbitro_mux4: directed scenarios then random traffic
// checked against a rule-level model of arbitration and the output register.
module tb_arbitro_mux4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [31:0] ent [4];
    logic [3:0]  trava;
    logic        pronto;
    logic [3:0]  ack;
    logic [1:0]  controlador;
    logic        saida_valida;
    logic [31:0] saida_dado;

    int checks = 0;
    int failures = 0;

    int          m_ptr;
    bit          m_full;
    logic [31:0] m_dado;
    int          m_ult;
    bit          m_ult_ok;
    bit          m_ret;

    always #5 clk = ~clk;

    arbitro_mux4 #(.LARGURA(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .entrada0     (ent[0]),
        .entrada1     (ent[1]),
        .entrada2     (ent[2]),
        .entrada3     (ent[3]),
`ifdef ARB_TRAVA_EN
        .trava        (trava),
`endif
        .pronto       (pronto),
        .ack          (ack),
        .controlador  (controlador),
        .saida_valida (saida_valida),
        .saida_dado   (saida_dado)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int m_winner(input logic [3:0] r);
        m_ret = 1'b0;
`ifdef ARB_TRAVA_EN
        if (m_ult_ok && trava[m_ult] && r[m_ult]) begin
            m_ret = 1'b1;
            return m_ult;
        end
`endif
        for (int k = 0; k < 4; k++) begin
            if (r[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return m_ptr;
    endfunction

    task automatic step(input logic rn, input logic [3:0] r, input logic p);
        int   w;
        bit   livre;
        bit   cap;
        logic [3:0] ea;
        logic [1:0] ec;
        @(negedge clk);
        reset_n = rn;
        req     = r;
        pronto  = p;
        #1;
        w     = m_winner(r);
        livre = !m_full || p;
        cap   = rn && livre && (r != 4'b0000);
        ea    = cap ? (4'b0001 << w) : 4'b0000;
        ec    = rn ? 2'(w) : 2'd0;
        chk("ack", 64'(ack), 64'(ea));
        chk("controlador", 64'(controlador), 64'(ec));
        @(posedge clk);
        if (!rn) begin
            m_ptr    = 0;
            m_full   = 1'b0;
            m_dado   = '0;
            m_ult_ok = 1'b0;
        end else if (cap) begin
            m_dado = ent[w];
            m_full = 1'b1;
            if (!m_ret) m_ptr = (w + 1) % 4;
            m_ult    = w;
            m_ult_ok = 1'b1;
        end else if (livre) begin
            m_full = 1'b0;
        end
        #1;
        chk("saida_valida", 64'(saida_valida), 64'(m_full));
        chk("saida_dado", 64'(saida_dado), 64'(m_dado));
    endtask

    initial begin
        reset_n = 1'b0;
        req     = 4'b0000;
        pronto  = 1'b0;
        trava   = 4'b0000;
        for (int i = 0; i < 4; i++) ent[i] = 32'hCAFE0000 + 32'(i);
        m_ptr = 0; m_full = 1'b0; m_dado = '0; m_ult = 0; m_ult_ok = 1'b0;

        // reset then single requester 2
        step(1'b0, 4'b0000, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        step(1'b1, 4'b0100, 1'b1);
        step(1'b1, 4'b0000, 1'b1);

        // all four requesting, back-to-back from ptr 0
        step(1'b0, 4'b0000, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 4'b1111, 1'b1);

        // pointer wrap and backpressure
        step(1'b0, 4'b0000, 1'b1);
        step(1'b1, 4'b1000, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 4'b0011, 1'b0);
        step(1'b1, 4'b0011, 1'b1);
        step(1'b1, 4'b1001, 1'b1);
        step(1'b1, 4'b0000, 1'b1);
        step(1'b1, 4'b0000, 1'b1);

        // reset while a word is held
        step(1'b1, 4'b0010, 1'b1);
        step(1'b1, 4'b0100, 1'b0);
        step(1'b0, 4'b0100, 1'b0);
        step(1'b1, 4'b0000, 1'b1);

`ifdef ARB_TRAVA_EN
        step(1'b0, 4'b0000, 1'b1);
        trava = 4'b0010;
        for (int i = 0; i < 3; i++) step(1'b1, 4'b0110, 1'b1);
        trava = 4'b0000;
        step(1'b1, 4'b0110, 1'b1);
        step(1'b1, 4'b0000, 1'b1);
`endif

        // random traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) ent[i] = $urandom;
`ifdef ARB_TRAVA_EN
            trava = 4'($urandom);
`endif
            step($urandom_range(0, 49) != 0, 4'($urandom), $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
